inst_fetch_ctrl: RTL and testbench

Fetch-stage controller that sits directly upstream of the instruction-RAM wrapper on the SRAM-like request/response bus. It holds the fetch PC and issues read-only word requests. It tracks the PCs of outstanding requests and buffers returned instructions in a small queue for the decode stage. Control-flow redirects are handled by flushing the queue and silently discarding responses to wrong-path requests already in flight.

---
 rtl/inst_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller for the instruction SRAM bus.
// Holds the fetch PC and issues word reads. It keeps the PCs of outstanding
// requests in a small FIFO and queues returned instructions for decode.
// A redirect flushes the queue. Responses to wrong-path requests that are
// still in flight are counted off and dropped as they return.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned IQ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        ds_allowin,
    output logic        fs_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);
    localparam int unsigned OP_W = $clog2(MAX_OUTST);
    localparam int unsigned OC_W = OP_W + 1;
    localparam int unsigned QP_W = $clog2(IQ_DEPTH);
    localparam int unsigned QC_W = QP_W + 1;

    logic [31:0]     pc_reg, pc_next;
    logic [OC_W-1:0] outst_cnt_reg, outst_cnt_next;
    logic [OC_W-1:0] discard_cnt_reg, discard_cnt_next;
    logic [OP_W-1:0] pf_wr_ptr_reg, pf_rd_ptr_reg;
    logic [QP_W-1:0] iq_wr_ptr_reg, iq_rd_ptr_reg;
    logic [QC_W-1:0] iq_count_reg, iq_count_next;

    logic [31:0] pf_mem      [MAX_OUTST];
    logic [31:0] iq_pc_mem   [IQ_DEPTH];
    logic [31:0] iq_inst_mem [IQ_DEPTH];

    logic        req_fire, resp_fire, iq_push, iq_pop, iq_empty;
    logic [31:0] credit_sum;
    logic [31:0] resp_pc;

    // Read-only word requests: the write-side signals are tied off.
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'd0;
    assign inst_sram_addr  = pc_reg & 32'hffff_fffc;

    // Credit rule: every accepted request already has an IQ slot reserved.
    // The request is not issued while reset is asserted.
    assign credit_sum    = 32'(outst_cnt_reg) + 32'(iq_count_reg);
    assign inst_sram_req = resetn && !redirect_valid
                           && (32'(outst_cnt_reg) < MAX_OUTST)
                           && (credit_sum < IQ_DEPTH);

    assign req_fire  = inst_sram_req && inst_sram_addr_ok;
    // A data_ok with nothing outstanding is stray and is ignored.
    assign resp_fire = inst_sram_data_ok && (outst_cnt_reg != '0);
    assign resp_pc   = pf_mem[pf_rd_ptr_reg];
    assign iq_push   = resp_fire && (discard_cnt_reg == '0) && !redirect_valid;

    assign iq_empty = (iq_count_reg == '0);
    assign fs_valid = !iq_empty && !redirect_valid;
    assign fs_pc    = iq_empty ? 32'd0 : iq_pc_mem[iq_rd_ptr_reg];
    assign fs_inst  = iq_empty ? 32'd0 : iq_inst_mem[iq_rd_ptr_reg];
    assign iq_pop   = fs_valid && ds_allowin;

    // Next-state arithmetic for the PC, the counters and the queue occupancy.
    always_comb begin
        outst_cnt_next   = outst_cnt_reg + OC_W'(req_fire) - OC_W'(resp_fire);
        discard_cnt_next = discard_cnt_reg;
        iq_count_next    = iq_count_reg + QC_W'(iq_push) - QC_W'(iq_pop);
        pc_next          = req_fire ? pc_reg + 32'd4 : pc_reg;
        if (redirect_valid) begin
            // Everything still in flight after this edge is wrong-path.
            discard_cnt_next = outst_cnt_next;
            iq_count_next    = '0;
            pc_next          = redirect_pc & 32'hffff_fffc;
        end else if (resp_fire && (discard_cnt_reg != '0)) begin
            discard_cnt_next = discard_cnt_reg - OC_W'(1);
        end
    end

    // Control state: PC, counters and FIFO/queue pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_reg          <= RESET_PC;
            outst_cnt_reg   <= '0;
            discard_cnt_reg <= '0;
            pf_wr_ptr_reg   <= '0;
            pf_rd_ptr_reg   <= '0;
            iq_wr_ptr_reg   <= '0;
            iq_rd_ptr_reg   <= '0;
            iq_count_reg    <= '0;
        end else begin
            pc_reg          <= pc_next;
            outst_cnt_reg   <= outst_cnt_next;
            discard_cnt_reg <= discard_cnt_next;
            iq_count_reg    <= iq_count_next;
            if (req_fire)  pf_wr_ptr_reg <= pf_wr_ptr_reg + OP_W'(1);
            if (resp_fire) pf_rd_ptr_reg <= pf_rd_ptr_reg + OP_W'(1);
            if (redirect_valid) begin
                iq_wr_ptr_reg <= '0;
                iq_rd_ptr_reg <= '0;
            end else begin
                if (iq_push) iq_wr_ptr_reg <= iq_wr_ptr_reg + QP_W'(1);
                if (iq_pop)  iq_rd_ptr_reg <= iq_rd_ptr_reg + QP_W'(1);
            end
        end
    end

    genvar gi;

    // PC FIFO storage: one register per outstanding-request slot.
    generate
        for (gi = 0; gi < MAX_OUTST; gi++) begin : g_pf
            logic [31:0] entry_reg;
            // Capture the fetch PC when this slot receives a handshake.
            always_ff @(posedge clk) begin
                if (req_fire && (pf_wr_ptr_reg == OP_W'(gi))) entry_reg <= pc_reg;
            end
            assign pf_mem[gi] = entry_reg;
        end
    endgenerate

    // Instruction queue storage: PC and instruction word per entry.
    generate
        for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_iq
            logic [31:0] pc_entry_reg;
            logic [31:0] inst_entry_reg;
            // Fill this entry from a kept response.
            always_ff @(posedge clk) begin
                if (iq_push && (iq_wr_ptr_reg == QP_W'(gi))) begin
                    pc_entry_reg   <= resp_pc;
                    inst_entry_reg <= inst_sram_rdata;
                end
            end
            assign iq_pc_mem[gi]   = pc_entry_reg;
            assign iq_inst_mem[gi] = inst_entry_reg;
        end
    endgenerate

    // Invariant monitors on the registered state.
    always @(posedge clk) begin
        if (resetn) begin
            assert (discard_cnt_reg <= outst_cnt_reg);
            assert (32'(outst_cnt_reg) <= MAX_OUTST);
            assert (32'(iq_count_reg) <= IQ_DEPTH);
            assert (!(iq_push && !iq_pop && (32'(iq_count_reg) == IQ_DEPTH)));
        end
    end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Testbench for inst_fetch_ctrl: an in-order SRAM model with random latency,
// directed scenarios, and a randomized run against a queue-based reference.
module tb_inst_fetch_ctrl;
    localparam logic [31:0] RESET_PC  = 32'h1c000000;
    localparam int          MAX_OUTST = 4;
    localparam int          IQ_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ds_allowin;
    logic        fs_valid;
    logic [31:0] fs_pc, fs_inst;

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST), .IQ_DEPTH(IQ_DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ds_allowin(ds_allowin),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .fs_inst(fs_inst)
    );

    int checks = 0;
    int errors = 0;
    int resp_pct = 100;
    int cyc = 0;
    bit verbose = 1'b1;

    // Memory-side model: accepted addresses awaiting a response, in order.
    logic [31:0] ram_q[$];
    int          ram_t[$];
    bit          ram_stale[$];

    // Per-cycle observations filled in by step().
    logic        o_req, o_fs_valid, o_hs, o_resp, o_resp_stale, o_pop;
    logic [31:0] o_addr, o_fs_pc, o_fs_inst;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
    endfunction

    // One clock cycle: drive inputs at negedge, sample outputs, update RAM model.
    task automatic step(input logic aok, input logic dsa, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        inst_sram_addr_ok = aok;
        ds_allowin        = dsa;
        redirect_valid    = rv;
        redirect_pc       = rpc;
        if (ram_q.size() > 0 && ram_t[0] < cyc && int'($urandom_range(99)) < resp_pct) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(ram_q[0]);
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = $urandom;
        end
        #1;
        o_req      = inst_sram_req;
        o_addr     = inst_sram_addr;
        o_fs_valid = fs_valid;
        o_fs_pc    = fs_pc;
        o_fs_inst  = fs_inst;
        o_hs       = inst_sram_req && aok;
        o_pop      = fs_valid && dsa;
        o_resp     = inst_sram_data_ok;
        o_resp_stale = 1'b0;
        if (o_resp) begin
            o_resp_stale = ram_stale[0];
            void'(ram_q.pop_front());
            void'(ram_t.pop_front());
            void'(ram_stale.pop_front());
        end
        if (rv) begin
            for (int i = 0; i < ram_stale.size(); i++) ram_stale[i] = 1'b1;
        end
        if (o_hs) begin
            ram_q.push_back(o_addr);
            ram_t.push_back(cyc);
            ram_stale.push_back(1'b0);
        end
        if (verbose) begin
            if (o_hs)  $display("cyc %0d request addr=%h", cyc, o_addr);
            if (o_pop) $display("cyc %0d decode pc=%h inst=%h", cyc, o_fs_pc, o_fs_inst);
            if (rv)    $display("cyc %0d redirect to %h", cyc, rpc);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; ds_allowin = 1'b0;
        ram_q.delete(); ram_t.delete(); ram_stale.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'd0;
        inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
        ds_allowin = 1'b1;
        #1;
        checks++; if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", inst_sram_req); end
        checks++; if (fs_valid !== 1'b0) begin errors++; $display("FAIL reset_fs_valid got %b want 0", fs_valid); end
        checks++; if (fs_pc !== 32'd0) begin errors++; $display("FAIL reset_fs_pc got %h want 0", fs_pc); end
        checks++; if (fs_inst !== 32'd0) begin errors++; $display("FAIL reset_fs_inst got %h want 0", fs_inst); end
        checks++; if (inst_sram_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", inst_sram_addr, RESET_PC); end
        checks++;
        if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'd2 || inst_sram_wstrb !== 4'd0 || inst_sram_wdata !== 32'd0) begin
            errors++;
            $display("FAIL const_outputs got wr=%b size=%0d wstrb=%h wdata=%h want 0/2/0/0",
                     inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
        // Release with a stray data_ok and nothing outstanding: it must be ignored.
        @(negedge clk);
        resetn = 1'b1; inst_sram_addr_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (fs_valid !== 1'b0) begin errors++; $display("FAIL stray_data_ok fs_valid got %b want 0", fs_valid); end
        inst_sram_data_ok = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        resp_pct = 100;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            checks++;
            if (o_req !== 1'b1 || o_addr !== RESET_PC + 32'(4 * k)) begin
                errors++; $display("FAIL stream_req k=%0d got req=%b addr=%h want 1 %h", k, o_req, o_addr, RESET_PC + 32'(4 * k));
            end
            checks++;
            if (o_fs_valid !== (k >= 2)) begin
                errors++; $display("FAIL stream_fs_valid k=%0d got %b want %b", k, o_fs_valid, k >= 2);
            end
            if (k >= 2) begin
                checks++;
                if (o_fs_pc !== RESET_PC + 32'(4 * (k - 2)) || o_fs_inst !== mem_word(RESET_PC + 32'(4 * (k - 2)))) begin
                    errors++; $display("FAIL stream_entry k=%0d got %h/%h want %h/%h", k, o_fs_pc, o_fs_inst,
                                       RESET_PC + 32'(4 * (k - 2)), mem_word(RESET_PC + 32'(4 * (k - 2))));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_hs = 0;
        int n_pop = 0;
        bit hs_seen = 1'b0;
        logic [31:0] exp_pc;
        do_reset();
        resp_pct = 100;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            if (o_hs) begin
                checks++;
                if (o_addr !== RESET_PC + 32'(4 * n_hs)) begin
                    errors++; $display("FAIL bp_addr n=%0d got %h want %h", n_hs, o_addr, RESET_PC + 32'(4 * n_hs));
                end
                n_hs++;
            end
        end
        checks++; if (n_hs != 4) begin errors++; $display("FAIL bp_handshakes got %0d want 4", n_hs); end
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b want 0", o_req); end
        checks++;
        if (o_fs_valid !== 1'b1 || o_fs_pc !== RESET_PC) begin
            errors++; $display("FAIL bp_head got valid=%b pc=%h want 1 %h", o_fs_valid, o_fs_pc, RESET_PC);
        end
        exp_pc = RESET_PC;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (o_pop) begin
                checks++;
                if (o_fs_pc !== exp_pc || o_fs_inst !== mem_word(exp_pc)) begin
                    errors++; $display("FAIL bp_drain got %h/%h want %h/%h", o_fs_pc, o_fs_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                n_pop++;
            end
            if (o_hs && !hs_seen) begin
                hs_seen = 1'b1;
                checks++;
                if (o_addr !== RESET_PC + 32'h10) begin
                    errors++; $display("FAIL bp_resume_addr got %h want %h", o_addr, RESET_PC + 32'h10);
                end
            end
        end
        checks++; if (!hs_seen) begin errors++; $display("FAIL bp_resume got no request want one"); end
        checks++; if (n_pop < 4) begin errors++; $display("FAIL bp_drain_count got %0d want >=4", n_pop); end
    endtask

    // Common tail: run until the first delivered entry and check it is the target.
    task automatic test_redirect();
        bit got = 1'b0;
        do_reset();
        resp_pct = 100;
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
        resp_pct = 0;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (o_fs_valid !== 1'b1 || o_fs_pc !== RESET_PC) begin
            errors++; $display("FAIL rd_setup got valid=%b pc=%h want 1 %h", o_fs_valid, o_fs_pc, RESET_PC);
        end
        step(1'b1, 1'b1, 1'b1, 32'h1c000100);
        checks++;
        if (o_req !== 1'b0 || o_fs_valid !== 1'b0) begin
            errors++; $display("FAIL rd_cycle got req=%b fs_valid=%b want 0 0", o_req, o_fs_valid);
        end
        resp_pct = 100;
        for (int k = 0; k < 12 && !got; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (k == 0) begin
                checks++;
                if (o_hs !== 1'b1 || o_addr !== 32'h1c000100) begin
                    errors++; $display("FAIL rd_first_req got hs=%b addr=%h want 1 1c000100", o_hs, o_addr);
                end
            end
            if (o_pop) begin
                got = 1'b1;
                checks++;
                if (o_fs_pc !== 32'h1c000100 || o_fs_inst !== mem_word(32'h1c000100)) begin
                    errors++; $display("FAIL rd_first_entry got %h/%h want 1c000100/%h", o_fs_pc, o_fs_inst, mem_word(32'h1c000100));
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rd_timeout got no entry want 1c000100"); end
    endtask

    task automatic test_redirect_data_ok();
        bit got = 1'b0;
        do_reset();
        resp_pct = 0;
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        resp_pct = 100;
        step(1'b0, 1'b1, 1'b1, 32'h1c000400);
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL rdo_req got %b want 0", o_req); end
        for (int k = 0; k < 12 && !got; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (o_pop) begin
                got = 1'b1;
                checks++;
                if (o_fs_pc !== 32'h1c000400 || o_fs_inst !== mem_word(32'h1c000400)) begin
                    errors++; $display("FAIL rdo_first_entry got %h/%h want 1c000400/%h", o_fs_pc, o_fs_inst, mem_word(32'h1c000400));
                end
            end
        end
        checks++; if (!got) begin errors++; $display("FAIL rdo_timeout got no entry want 1c000400"); end
    endtask

    task automatic test_addr_stall();
        do_reset();
        resp_pct = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            checks++;
            if (o_req !== 1'b1 || o_addr !== RESET_PC) begin
                errors++; $display("FAIL stall k=%0d got req=%b addr=%h want 1 %h", k, o_req, o_addr, RESET_PC);
            end
        end
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (o_addr !== RESET_PC) begin errors++; $display("FAIL stall_hs_addr got %h want %h", o_addr, RESET_PC); end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++;
        if (o_req !== 1'b1 || o_addr !== RESET_PC + 32'd4) begin
            errors++; $display("FAIL stall_next_addr got req=%b addr=%h want 1 %h", o_req, o_addr, RESET_PC + 32'd4);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pops[$];
        do_reset();
        resp_pct = 100;
        step(1'b0, 1'b1, 1'b1, 32'h1c000202);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (o_hs !== 1'b1 || o_addr !== 32'h1c000200) begin errors++; $display("FAIL align_addr got hs=%b addr=%h want 1 1c000200", o_hs, o_addr); end
        step(1'b0, 1'b1, 1'b1, 32'hfffffffc);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (o_hs !== 1'b1 || o_addr !== 32'hfffffffc) begin errors++; $display("FAIL wrap_addr0 got hs=%b addr=%h want 1 fffffffc", o_hs, o_addr); end
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++; if (o_hs !== 1'b1 || o_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_addr1 got hs=%b addr=%h want 1 00000000", o_hs, o_addr); end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            if (o_pop) pops.push_back(o_fs_pc);
        end
        checks++;
        if (pops.size() != 2) begin
            errors++; $display("FAIL wrap_count got %0d want 2", pops.size());
        end else if (pops[0] !== 32'hfffffffc || pops[1] !== 32'h00000000) begin
            errors++; $display("FAIL wrap_entries got %h %h want fffffffc 00000000", pops[0], pops[1]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        resp_pct = 100;
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (fs_valid !== 1'b0 || inst_sram_req !== 1'b0 || inst_sram_addr !== RESET_PC) begin
            errors++; $display("FAIL async_reset got valid=%b req=%b addr=%h want 0 0 %h", fs_valid, inst_sram_req, inst_sram_addr, RESET_PC);
        end
        ram_q.delete(); ram_t.delete(); ram_stale.delete();
    endtask

    task automatic test_random();
        logic [31:0] exp_req_pc, exp_dec_pc, rpc;
        int m_iq = 0;
        int n_pop = 0;
        int outst;
        bit rv, aok, dsa, exp_req, exp_fv;
        do_reset();
        verbose = 1'b0;
        exp_req_pc = RESET_PC;
        exp_dec_pc = RESET_PC;
        for (int k = 0; k < 3000; k++) begin
            resp_pct = (k < 1500) ? 60 : 95;
            rv  = ($urandom_range(99) < 3);
            rpc = $urandom;
            aok = ($urandom_range(99) < 70);
            dsa = ($urandom_range(99) < 65);
            outst = ram_q.size();
            step(aok, dsa, rv, rpc);
            exp_req = !rv && (outst < MAX_OUTST) && (outst + m_iq < IQ_DEPTH);
            checks++;
            if (o_req !== exp_req) begin errors++; $display("FAIL rnd_req k=%0d got %b want %b", k, o_req, exp_req); end
            exp_fv = (m_iq > 0) && !rv;
            checks++;
            if (o_fs_valid !== exp_fv) begin errors++; $display("FAIL rnd_fs_valid k=%0d got %b want %b", k, o_fs_valid, exp_fv); end
            if (o_pop) begin
                checks++;
                if (o_fs_pc !== exp_dec_pc || o_fs_inst !== mem_word(exp_dec_pc)) begin
                    errors++; $display("FAIL rnd_entry k=%0d got %h/%h want %h/%h", k, o_fs_pc, o_fs_inst, exp_dec_pc, mem_word(exp_dec_pc));
                end
                exp_dec_pc += 32'd4;
                m_iq--;
                n_pop++;
            end
            if (o_hs) begin
                checks++;
                if (o_addr !== exp_req_pc) begin errors++; $display("FAIL rnd_addr k=%0d got %h want %h", k, o_addr, exp_req_pc); end
                exp_req_pc += 32'd4;
            end
            if (o_resp && !o_resp_stale && !rv) m_iq++;
            if (rv) begin
                m_iq = 0;
                exp_req_pc = rpc & 32'hffff_fffc;
                exp_dec_pc = rpc & 32'hffff_fffc;
            end
            checks++;
            if (ram_q.size() > MAX_OUTST) begin errors++; $display("FAIL rnd_outstanding k=%0d got %0d want <=%0d", k, ram_q.size(), MAX_OUTST); end
        end
        checks++; if (n_pop < 300) begin errors++; $display("FAIL rnd_progress got %0d want >=300", n_pop); end
        verbose = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; ds_allowin = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_data_ok();
        test_addr_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
